muldiv_iter: RTL
================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit for the EXE stage.
- Successor to the fixed 32-bit start/ready divider. One shared shift/add-subtract datapath serves MULT, MULTU, DIV and DIVU, one bit per cycle.
- Produces HI/LO for the hilo write path.
- Has a busy/ready/annul handshake so the hazard unit can stall EXE and kill the operation on flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  request; accepted only when busy=0
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- annul  in  1  abandon the in-flight op (EXE flush/exception)
- a  in  WIDTH  multiplicand / dividend; sampled with start
- b  in  WIDTH  multiplier / divisor; sampled with start
- busy  out  1  high in every state except IDLE
- ready  out  1  one-cycle pulse; hi/lo valid from this cycle on
- hi  out  WIDTH  product[2W-1:W] or remainder
- lo  out  WIDTH  product[W-1:0] or quotient

Behaviour:
- Reset values: state=IDLE, busy=0, ready=0, hi=0, lo=0, counter=0.
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - start=1 & annul=0 latches the operation. Latched values: |a| and |b| for signed ops, raw a and b for unsigned ops, sign bits sa and sb, and op.
  - Counter is set to WIDTH; state goes to CALC.
- CALC, one iteration per cycle:
  - Multiply: shift-add into a 2W accumulator.
  - Divide: restoring shift-subtract on a {rem, quo} register.
  - Counter decrements; when it reaches 1, the next state is FIX.
- FIX, sign fixup; hi/lo are registered at the end of this cycle:
  - Signed multiply: product negated if sa^sb.
  - Signed divide: quotient negated if sa^sb; remainder negated if sa.
- DONE: ready=1 for exactly this cycle, then IDLE.
- Latency: start in cycle N gives ready in cycle N+WIDTH+2 (34 for WIDTH=32). busy is high from cycle N+1 through the ready cycle inclusive.
- hi/lo hold their value until the next FIX; they are never cleared by annul.
- start while busy=1 is ignored; the bench must not expect queueing.
- annul=1 in any state forces IDLE at the next edge. In that case there is no ready, hi/lo are unchanged, and the partial result is discarded.
  - annul and start in the same IDLE cycle: annul wins, nothing is accepted.
  - annul in the DONE cycle: ready is still high in that cycle, since it was already registered.
- Divide by zero:
  - Iteration runs normally; no exception is raised.
  - Fixed result: lo = all ones, hi = a (the original dividend, sign preserved).
  - Signed divide by zero is not sign-fixed.
- Overflow: DIV of -2^(W-1) by -1 gives lo=0x80000000 (W=32) and hi=0, wrapping with no flag.
- Arithmetic rules:
  - Absolute values are computed as W-bit unsigned values, so |-2^(W-1)| = 2^(W-1).
  - All negation is two's complement at W or 2W bits.
- Reset asserted mid-operation: the reset values above apply at the next edge.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - If the latched b==0, or a==0 on multiply, CALC is skipped: IDLE goes to FIX directly.
  - FIX loads the fixed result: product 0; for divide by zero the result given above; for a==0 divide, quotient 0 and remainder 0.
  - ready arrives in cycle N+2.
- When undefined: every op takes the full WIDTH+2 latency; results are identical either way.

Decomposition:
- Shared package muldiv_pkg holds:
  - the op encodings (OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11);
  - the state encodings (IDLE, CALC, FIX, DONE);
  - an is_signed(op) helper.
- One natural sub-module: muldiv_step, a combinational single-iteration kernel. Inputs are the accumulator, the operand and is_div; outputs are the next accumulator and the quotient bit. It is instantiated once in muldiv_iter.

Test Plan:
- DIVU, a=100, b=7 → ready at cycle N+34; lo=14, hi=2; busy high for exactly 34 cycles.
- DIV, a=-7 (0xFFFFFFF9), b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIV of 0x80000000 by 0xFFFFFFFF → lo=0x80000000, hi=0.
- MULT, a=0xFFFFFFFF (-1), b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFFB. MULTU with the same operands → hi=0x00000004, lo=0xFFFFFFFB.
- Start a DIVU, assert annul at cycle N+10 → IDLE at N+11, no ready, hi/lo keep the previous result. A start issued while busy is ignored.
- DIVU, b=0, a=0x1234 → lo=0xFFFFFFFF, hi=0x1234. Latency is 34 without MULDIV_EARLY_OUT_EN and 2 with it.
- WIDTH=8 instance, DIVU 200/9 → lo=22, hi=2, ready at N+10. Assert rst in a CALC cycle → busy=0, hi=lo=0 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// Single iteration of the shared datapath: shift-add multiply or restoring shift-subtract divide.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shl;
  logic [WIDTH:0] diff;

  always_comb begin
    sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
    shl   = acc[2*WIDTH-1:WIDTH-1];
    diff  = shl - {1'b0, operand};
    q_bit = is_div & ~diff[WIDTH];
    // divide leaves the quotient slot at 0; the caller inserts q_bit
    if (is_div) begin
      acc_next = {(q_bit ? diff[WIDTH-1:0] : shl[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end else if (acc[0]) begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end else begin
      acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit, one bit per cycle, busy/ready/annul handshake.
// Optional MULDIV_EARLY_OUT_EN: zero-operand ops skip CALC and finish two cycles after start.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one shift/add-subtract iteration per cycle
// FIX   | sign fixup, hi/lo registered at end of cycle
// DONE  | ready pulse, back to IDLE
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             annul,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, step_acc, prod_fix;
  logic [WIDTH-1:0]   opnd, a_abs, b_abs, quo_fix, rem_src, rem_fix;
  logic [1:0]         op_r;
  logic               sa, sb, b_zero, q_bit, accept, skip_in;
`ifdef MULDIV_EARLY_OUT_EN
  logic               skip_r;
`endif

  assign accept = start & ~annul;
  assign a_abs  = (is_signed(op) & a[WIDTH-1]) ? -a : a;
  assign b_abs  = (is_signed(op) & b[WIDTH-1]) ? -b : b;
  assign busy   = (state != IDLE);
  assign ready  = (state == DONE);

`ifdef MULDIV_EARLY_OUT_EN
  assign skip_in = (b == '0) | (~is_div(op) & (a == '0));
`else
  assign skip_in = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .is_div   (is_div(op_r)),
    .acc_next (step_acc),
    .q_bit    (q_bit)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = skip_in ? FIX : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (annul) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Divide by zero iterates to rem=|a|, so negating by sa restores the original dividend.
  always_comb begin
    prod_fix = (sa ^ sb) ? -acc : acc;
    rem_src  = acc[2*WIDTH-1:WIDTH];
`ifdef MULDIV_EARLY_OUT_EN
    if (skip_r) begin
      prod_fix = '0;
      rem_src  = acc[WIDTH-1:0];
    end
`endif
    quo_fix = ((sa ^ sb) & ~b_zero) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    if (b_zero) quo_fix = '1;
    rem_fix = sa ? -rem_src : rem_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      op_r   <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      b_zero <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULDIV_EARLY_OUT_EN
      skip_r <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_r   <= op;
            sa     <= is_signed(op) & a[WIDTH-1];
            sb     <= is_signed(op) & b[WIDTH-1];
            b_zero <= (b == '0);
            cnt    <= CNT_W'(WIDTH);
            acc    <= {{WIDTH{1'b0}}, (is_div(op) ? a_abs : b_abs)};
            opnd   <= is_div(op) ? b_abs : a_abs;
`ifdef MULDIV_EARLY_OUT_EN
            skip_r <= skip_in;
`endif
          end
        end
        CALC: begin
          acc <= is_div(op_r) ? {step_acc[2*WIDTH-1:1], q_bit} : step_acc;
          cnt <= cnt - CNT_W'(1);
        end
        FIX: begin
          if (!annul) begin
            hi <= is_div(op_r) ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
            lo <= is_div(op_r) ? quo_fix : prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
